fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Read-side consumer of the asynchronous FIFO. It runs in the FIFO read clock domain, pops one word at a time through the FIFO read port, and serialises each word as an asynchronous serial frame: one start bit, data LSB first, optional parity, one stop bit. It drains the FIFO onto a single serial line with no gaps between frames while data remains.

Parameters:
Data_width, 8, width of a FIFO word and of the serial data field.
Clks_per_bit, 16, clk cycles per serial bit; legal range is 2 or more.
Parity_en, 0, 1 inserts a parity bit after the data bits.
Parity_odd, 0, 0 selects even parity, 1 selects odd parity (used only when Parity_en=1).

Ports:
clk  input  1  clock; the same clock as the FIFO clk_read.
rst  input  1  asynchronous, active-low reset.
fifo_empty  input  1  FIFO empty flag, read-domain.
fifo_rd_en  output  1  FIFO Read_enable; one-cycle pulse per word.
fifo_data  input  Data_width  FIFO data_out; valid on the cycle after the fifo_rd_en cycle.
tx_out  output  1  serial line; idles high.
busy  output  1  high in every state other than IDLE.
frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Reset (rst=0, asserted at any time, including mid-frame):
  - State goes to IDLE.
  - Outputs: tx_out=1, fifo_rd_en=0, busy=0, frame_done=0.
  - Bit counter, baud counter and shift register clear to 0.
  - A partially sent frame is abandoned. The popped word is lost and is not re-read.
- All outputs are registered or Moore-decoded from state. No combinational path runs from fifo_empty to fifo_rd_en.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx_out=1. If fifo_empty=0 at a clock edge, go to FETCH.
- FETCH: exactly one cycle with fifo_rd_en=1. Go to LOAD.
- LOAD: one cycle. Capture fifo_data into the shift register and compute parity = XOR of the data bits, XORed with Parity_odd. Go to START.
- START: tx_out=0 for Clks_per_bit cycles. Go to DATA.
- DATA:
  - tx_out = shift register bit 0. After each Clks_per_bit cycles, shift right and increment the bit counter.
  - After Data_width bits, go to PARITY if Parity_en=1, otherwise to STOP.
- PARITY: tx_out = parity bit for Clks_per_bit cycles. Go to STOP.
- STOP:
  - tx_out=1 for Clks_per_bit cycles. frame_done=1 in the final cycle only.
  - On exit, sample fifo_empty: if 0 go directly to FETCH (back-to-back); if 1 go to IDLE.
- Baud counter: width clog2(Clks_per_bit). Counts 0 to Clks_per_bit-1 and wraps. Cleared on every state entry.
- Frame length: (2 + Data_width + Parity_en) × Clks_per_bit cycles. This is 160 cycles at the defaults.
- Latency: from the edge where IDLE sees fifo_empty=0 to the first start-bit cycle is 2 cycles (FETCH, then LOAD).
- Inter-frame idle high time in back-to-back operation is exactly 2 cycles (FETCH, LOAD).
- fifo_rd_en is never asserted while fifo_empty=1 is sampled. The block performs at most one pop per frame.
- The empty flag deasserts late because of pointer synchronisation. This only delays the start of a frame and is not an error.
- A word arriving in the FIFO mid-frame waits until STOP exits.

Test Plan:
- Reset values: hold rst=0 with fifo_empty=0 -> tx_out=1, fifo_rd_en=0, busy=0 throughout. Release rst with fifo_empty=1 -> block stays in IDLE with no rd_en pulse for 200 cycles.
- Single word 0x4D (Data_width=8, Clks_per_bit=16, no parity):
  - Exactly one rd_en pulse.
  - Start bit begins 2 cycles after empty deasserts.
  - Line sequence 0, 1,0,1,1,0,0,1,0, 1, with each bit 16 cycles wide.
  - frame_done pulses at cycle 160 of the frame; busy drops the cycle after.
- Back-to-back 0x4D then 0xFF with both words queued:
  - Two rd_en pulses 162 cycles apart.
  - Exactly 2 idle-high cycles between the first stop bit and the second start bit.
  - Second frame carries data bits 8×1.
- Parity, Parity_en=1:
  - Even parity on 0x4D -> parity bit 0.
  - Odd parity on 0x4D -> parity bit 1.
  - Frame length 176 cycles.
- Reset mid-frame: assert rst during DATA bit 3 -> tx_out goes to 1 immediately. After release with FIFO non-empty, the next word is fetched and a full frame is sent with no rd_en during reset.
- Drain 32 words: fill the FIFO to full, then let the block drain it -> 32 rd_en pulses, 32 frame_done pulses, data order preserved, block returns to IDLE with fifo_empty=1.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Drains the async FIFO read port onto a UART-style serial line:
// start bit, data LSB first, optional parity, one stop bit.
module fifo_uart_tx #(
    parameter int Data_width   = 8,
    parameter int Clks_per_bit = 16,
    parameter int Parity_en    = 0,
    parameter int Parity_odd   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [Data_width-1:0] fifo_data,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = (Clks_per_bit > 1) ? $clog2(Clks_per_bit) : 1;
    localparam int BW = $clog2(Data_width + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(Clks_per_bit - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(Data_width - 1);
    localparam logic          PAR_ODD   = (Parity_odd != 0);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t                state, nxt;
    logic [CW-1:0]         baud;
    logic [BW-1:0]         bitcnt;
    logic [Data_width-1:0] shreg;
    logic                  par;
    logic                  baud_end;

    assign baud_end = (baud == BAUD_LAST);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) nxt = FETCH;
            FETCH:   nxt = LOAD;
            LOAD:    nxt = START;
            START:   if (baud_end) nxt = DATA;
            DATA:    if (baud_end && bitcnt == BIT_LAST)
                         nxt = (Parity_en != 0) ? PARITY : STOP;
            PARITY:  if (baud_end) nxt = STOP;
            // Empty is sampled only at stop exit so a word arriving mid-frame waits.
            STOP:    if (baud_end) nxt = fifo_empty ? IDLE : FETCH;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            baud   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
        end else begin
            state <= nxt;
            // Baud restarts on every state entry and wraps within a bit.
            if (nxt != state || baud_end) baud <= '0;
            else                          baud <= baud + 1'b1;
            if (state == LOAD) begin
                shreg  <= fifo_data;
                par    <= (^fifo_data) ^ PAR_ODD;
                bitcnt <= '0;
            end else if (state == DATA && baud_end) begin
                shreg  <= shreg >> 1;
                bitcnt <= bitcnt + 1'b1;
            end
        end
    end

    // Outputs decode from state/registers only, so reset forces the line high at once.
    always_comb begin
        tx_out     = 1'b1;
        fifo_rd_en = 1'b0;
        busy       = (state != IDLE);
        frame_done = 1'b0;
        case (state)
            FETCH:   fifo_rd_en = 1'b1;
            START:   tx_out = 1'b0;
            DATA:    tx_out = shreg[0];
            PARITY:  tx_out = par;
            STOP:    frame_done = baud_end;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: a queue models the FIFO read port; line samples are logged
// per cycle and frames are checked against hand-computed bit patterns.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       m_empty, m_rd, m_tx, m_busy, m_fd;
    logic [7:0] m_data;
    logic       p_empty;
    logic [7:0] p_data;
    logic       e_rd, e_tx, e_busy, e_fd;
    logic       o_rd, o_tx, o_busy, o_fd;

    fifo_uart_tx u_m (
        .clk(clk), .rst(rst), .fifo_empty(m_empty), .fifo_rd_en(m_rd),
        .fifo_data(m_data), .tx_out(m_tx), .busy(m_busy), .frame_done(m_fd));

    fifo_uart_tx #(.Parity_en(1), .Parity_odd(0)) u_e (
        .clk(clk), .rst(rst), .fifo_empty(p_empty), .fifo_rd_en(e_rd),
        .fifo_data(p_data), .tx_out(e_tx), .busy(e_busy), .frame_done(e_fd));

    fifo_uart_tx #(.Parity_en(1), .Parity_odd(1)) u_o (
        .clk(clk), .rst(rst), .fifo_empty(p_empty), .fifo_rd_en(o_rd),
        .fifo_data(p_data), .tx_out(o_tx), .busy(o_busy), .frame_done(o_fd));

    logic       tx_m[$], tx_e[$], tx_o[$], busy_m[$], busy_p[$];
    int         rd_m[$], fd_m[$], rd_e[$], rd_o[$], fd_e[$], fd_o[$];
    logic [7:0] mq[$];
    logic [7:0] p_word;
    logic [7:0] want_w[32];
    int cyc = 0, viol = 0, ntest = 0, nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        ntest++;
        assert (obs === want) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // One clock: sample at negedge into index cyc, then service pops after the edge.
    task automatic tick();
        logic mr, pr;
        @(negedge clk);
        tx_m.push_back(m_tx);
        tx_e.push_back(e_tx);
        tx_o.push_back(o_tx);
        busy_m.push_back(m_busy);
        busy_p.push_back(e_busy | o_busy);
        if (m_rd) begin rd_m.push_back(cyc); if (m_empty) viol++; end
        if (m_fd) fd_m.push_back(cyc);
        if (e_rd) rd_e.push_back(cyc);
        if (o_rd) rd_o.push_back(cyc);
        if (e_fd) fd_e.push_back(cyc);
        if (o_fd) fd_o.push_back(cyc);
        if ((e_rd || o_rd) && p_empty) viol++;
        mr = m_rd;
        pr = e_rd | o_rd;
        cyc++;
        @(posedge clk);
        #1;
        if (mr) begin
            if (mq.size() > 0) m_data = mq.pop_front();
            m_empty = (mq.size() == 0);
        end
        if (pr) begin p_data = p_word; p_empty = 1'b1; end
    endtask

    task automatic check_frame(input string tag, input int which, input int st,
                               input logic [15:0] pat, input int nb);
        int errs = 0;
        logic v;
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < 16; c++) begin
                v = (which == 0) ? tx_m[st + 16*b + c] :
                    (which == 1) ? tx_e[st + 16*b + c] : tx_o[st + 16*b + c];
                if (v !== pat[b]) errs++;
            end
        chk(tag, errs, 0);
    endtask

    initial begin
        int t0, t1, t2, t3, t4, nr, nf, bad, errs, s;
        logic [7:0] w;

        rst = 1'b0; m_empty = 1'b0; p_empty = 1'b0;
        m_data = '0; p_data = '0; p_word = '0;

        // Reset held with FIFO claiming data.
        repeat (10) tick();
        bad = 0;
        for (int i = 0; i < 10; i++)
            if (tx_m[i] !== 1'b1 || busy_m[i] !== 1'b0 || tx_e[i] !== 1'b1) bad++;
        chk("reset_hold_outputs", bad, 0);
        chk("reset_hold_no_rd", rd_m.size() + rd_e.size(), 0);

        m_empty = 1'b1; p_empty = 1'b1; rst = 1'b1;
        repeat (200) tick();
        bad = 0;
        for (int i = 10; i < 210; i++)
            if (tx_m[i] !== 1'b1 || busy_m[i] !== 1'b0) bad++;
        chk("idle_empty_line_high", bad, 0);
        chk("idle_empty_no_rd", rd_m.size(), 0);

        // Single word 0x4D.
        t0 = cyc;
        mq.push_back(8'h4D); m_empty = 1'b0;
        repeat (200) tick();
        chk("single_rd_count", rd_m.size(), 1);
        chk("single_rd_cycle", rd_m[0], t0 + 1);
        chk("single_load_high", tx_m[t0 + 2], 1'b1);
        check_frame("single_frame_4d", 0, t0 + 3, 16'b1_01001101_0, 10);
        chk("single_fd_count", fd_m.size(), 1);
        chk("single_fd_cycle", fd_m[0], t0 + 162);
        chk("single_busy_last", busy_m[t0 + 162], 1'b1);
        chk("single_busy_drop", busy_m[t0 + 163], 1'b0);

        // Back-to-back 0x4D, 0xFF.
        t1 = cyc;
        mq.push_back(8'h4D); mq.push_back(8'hFF); m_empty = 1'b0;
        repeat (340) tick();
        chk("b2b_rd_count", rd_m.size(), 3);
        chk("b2b_rd_spacing", rd_m[2] - rd_m[1], 162);
        check_frame("b2b_frame1", 0, t1 + 3, 16'b1_01001101_0, 10);
        chk("b2b_gap_high", {30'd0, tx_m[t1 + 163], tx_m[t1 + 164]}, 32'd3);
        chk("b2b_start2_low", tx_m[t1 + 165], 1'b0);
        check_frame("b2b_frame2_ff", 0, t1 + 165, 16'b1_11111111_0, 10);
        chk("b2b_fd_cycle2", fd_m[2], t1 + 324);
        chk("b2b_idle_after", busy_m[t1 + 330], 1'b0);

        // Parity on 0x4D (four ones): even -> 0, odd -> 1; 176-cycle frame.
        t2 = cyc;
        p_word = 8'h4D; p_empty = 1'b0;
        repeat (200) tick();
        chk("par_rd_even", rd_e.size(), 1);
        chk("par_rd_odd_cycle", rd_o[0], t2 + 1);
        check_frame("par_even_frame", 1, t2 + 3, 16'b1_0_01001101_0, 11);
        check_frame("par_odd_frame", 2, t2 + 3, 16'b1_1_01001101_0, 11);
        chk("par_even_fd", fd_e[0], t2 + 178);
        chk("par_odd_fd", fd_o[0], t2 + 178);
        chk("par_busy_drop", busy_p[t2 + 179], 1'b0);

        // Reset during data bit 3 of 0xA5; 0xA5 is lost and 0x3C follows.
        t3 = cyc;
        mq.push_back(8'hA5); mq.push_back(8'h3C); m_empty = 1'b0;
        while (cyc < t3 + 70) tick();
        check_frame("rstmid_partial", 0, t3 + 3, 16'b0101_0, 4);
        nr = rd_m.size();
        rst = 1'b0;
        #1;
        chk("rstmid_tx_immediate", m_tx, 1'b1);
        chk("rstmid_busy_immediate", m_busy, 1'b0);
        repeat (5) tick();
        chk("rstmid_no_rd_in_reset", rd_m.size(), nr);
        rst = 1'b1;
        t4 = cyc;
        repeat (170) tick();
        chk("rstmid_one_rd_after", rd_m.size(), nr + 1);
        chk("rstmid_rd_cycle", rd_m[nr], t4 + 1);
        check_frame("rstmid_frame_3c", 0, t4 + 3, 16'b1_00111100_0, 10);
        chk("rstmid_fifo_drained", m_empty, 1'b1);

        // Drain 32 queued words.
        nr = rd_m.size();
        nf = fd_m.size();
        for (int i = 0; i < 32; i++) begin
            want_w[i] = 8'(i * 37 + 5);
            mq.push_back(want_w[i]);
        end
        m_empty = 1'b0;
        repeat (32 * 162 + 20) tick();
        chk("drain_rd_count", rd_m.size() - nr, 32);
        chk("drain_fd_count", fd_m.size() - nf, 32);
        errs = 0;
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            s = rd_m[nr + k] + 2;
            w = '0;
            for (int b = 0; b < 8; b++) w[b] = tx_m[s + 16*(b + 1) + 8];
            if (w !== want_w[k]) errs++;
            if (k > 0 && rd_m[nr + k] - rd_m[nr + k - 1] != 162) bad++;
        end
        chk("drain_data_order", errs, 0);
        chk("drain_rd_spacing", bad, 0);
        chk("drain_idle_busy", busy_m[cyc - 1], 1'b0);
        chk("drain_idle_line", tx_m[cyc - 1], 1'b1);
        chk("drain_fifo_empty", m_empty, 1'b1);

        chk("rd_while_empty", viol, 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
